// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle used on both sides of pipe_stage_reg.
//   master: drives valid and data, samples ready (producer side)
//   slave : samples valid and data, drives ready (consumer side)
// Signals:
//   valid  producer holds a valid payload
//   ready  consumer can accept; a transfer occurs when valid && ready
//   data   payload, DATA_W bits
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 64
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer and
// a synchronous flush that inserts a programmable bubble.
// Parameters:
//   DATA_W      payload width (>= 1)
//   SKID        1: two entries, registered in_ready; 0: one entry, combinational in_ready
//   BUBBLE_VAL  value driven on out_if.data whenever out_if.valid is low
// Ports:
//   clk     clock, all state updates on the rising edge
//   rst     synchronous active-high reset
//   flush   squash all held payloads and any payload accepted this cycle
//   in_if   upstream handshake (slave side)
//   out_if  downstream handshake (master side)
//   level   entries held: 0, 1 or 2 (2 only when SKID = 1)
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 64,
  parameter bit                SKID       = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  pipe_stage_reg_if.slave          in_if,
  pipe_stage_reg_if.master         out_if,
  output logic [1:0]               level
);

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;

  logic in_acc, out_acc;
  logic out_valid, in_ready;

  assign out_valid = (state_q != StEmpty);

  // With SKID = 0 the stage can only accept when its single entry is leaving or empty.
  assign in_ready = SKID ? in_ready_q : (out_if.ready || !out_valid);

  assign in_acc  = in_if.valid && in_ready;
  assign out_acc = out_valid && out_if.ready;

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_valid ? main_q : BUBBLE_VAL;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      StEmpty: begin
        if (in_acc) begin
          main_d  = in_if.data;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (in_acc && out_acc) begin
          main_d = in_if.data;
        end else if (in_acc) begin
          // Only reachable with SKID = 1; SKID = 0 never accepts while stalled.
          skid_d  = in_if.data;
          state_d = StFull;
        end else if (out_acc) begin
          main_d  = BUBBLE_VAL;
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_acc) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = StBusy;
        end
      end
      default: begin
        main_d  = BUBBLE_VAL;
        skid_d  = '0;
        state_d = StEmpty;
      end
    endcase

    // Flush wins over the handshake; an out_acc this cycle has already completed downstream.
    if (flush) begin
      state_d = StEmpty;
      main_d  = BUBBLE_VAL;
      skid_d  = '0;
    end

    in_ready_d = (state_d != StFull);
  end

  always_comb begin
    level = 2'd0;
    unique case (state_q)
      StEmpty: level = 2'd0;
      StBusy:  level = 2'd1;
      StFull:  level = 2'd2;
      default: level = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      main_q     <= BUBBLE_VAL;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 instance (bubble 0) and one SKID=0 instance
// (bubble 0x13), directed vector tables, a reset+flush sequence and a random soak against a
// queue model.
module tb_pipe_stage_reg;
  localparam int unsigned   DW  = 64;
  localparam logic [DW-1:0] BV0 = 64'h13;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush1, flush0;
  logic [1:0] level1, level0;

  pipe_stage_reg_if #(.DATA_W(DW)) in1 ();
  pipe_stage_reg_if #(.DATA_W(DW)) out1 ();
  pipe_stage_reg_if #(.DATA_W(DW)) in0 ();
  pipe_stage_reg_if #(.DATA_W(DW)) out0 ();

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .BUBBLE_VAL(64'h0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_if(in1), .out_if(out1), .level(level1)
  );
  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .BUBBLE_VAL(BV0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_if(in0), .out_if(out0), .level(level0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [63:0] od;
    logic [1:0]  lvl;
    logic        ir;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] q [2][$];
  logic [63:0] bv [2];

  vec_t v1 [27];
  vec_t v0 [7];

  function automatic vec_t mk(logic iv, logic [63:0] id, logic ordy, logic fl,
                              logic ov, logic [63:0] od, logic [1:0] lvl, logic ir);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.od = od; v.lvl = lvl; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a vector at the falling edge, check outputs 1 time unit later.
  task automatic step(input bit sel, input vec_t v, input string tag);
    @(negedge clk);
    if (sel) begin
      in1.valid = v.iv; in1.data = v.id; out1.ready = v.ordy; flush1 = v.fl;
    end else begin
      in0.valid = v.iv; in0.data = v.id; out0.ready = v.ordy; flush0 = v.fl;
    end
    #1;
    if (sel) begin
      chk({tag, ".ov"},  64'(out1.valid), 64'(v.ov));
      chk({tag, ".od"},  out1.data,       v.od);
      chk({tag, ".lvl"}, 64'(level1),     64'(v.lvl));
      chk({tag, ".ir"},  64'(in1.ready),  64'(v.ir));
    end else begin
      chk({tag, ".ov"},  64'(out0.valid), 64'(v.ov));
      chk({tag, ".od"},  out0.data,       v.od);
      chk({tag, ".lvl"}, 64'(level0),     64'(v.lvl));
      chk({tag, ".ir"},  64'(in0.ready),  64'(v.ir));
    end
  endtask

  task automatic idle_all();
    in1.valid = 1'b0; in1.data = '0; out1.ready = 1'b0; flush1 = 1'b0;
    in0.valid = 1'b0; in0.data = '0; out0.ready = 1'b0; flush0 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Queue model: checks the cycle's outputs, then applies the handshake of the coming edge.
  task automatic soak_chk(input int s, input logic iv, input logic ir, input logic [63:0] id,
                          input logic ov, input logic ordy, input logic [63:0] od,
                          input logic fl, input logic [1:0] lvl);
    int   n      = q[s].size();
    logic exp_ir = (s == 1) ? (n < 2) : (ordy || n == 0);
    chk($sformatf("soak%0d.lvl", s), 64'(lvl), 64'(n));
    chk($sformatf("soak%0d.ov", s),  64'(ov),  64'(n != 0));
    chk($sformatf("soak%0d.ir", s),  64'(ir),  64'(exp_ir));
    if (n == 0) chk($sformatf("soak%0d.bubble", s), od, bv[s]);
    else        chk($sformatf("soak%0d.od", s),     od, q[s][0]);
    if (n != 0 && ordy) void'(q[s].pop_front());
    if (fl) q[s].delete();
    else if (iv && exp_ir) q[s].push_back(id);
  endtask

  initial begin
    bv[0] = BV0;
    bv[1] = 64'h0;
    rst = 1'b1;
    idle_all();

    // SKID=1: stream 1..8, back-pressure A/B/C, flush in FULL, flush discards in_acc.
    for (int i = 0; i < 8; i++)
      v1[i] = mk(1'b1, 64'(i + 1), 1'b1, 1'b0, (i != 0), 64'(i), 2'((i != 0) ? 1 : 0), 1'b1);
    v1[8]  = mk(0, 64'h0,  1, 0, 1, 64'h8,  1, 1);
    v1[9]  = mk(0, 64'h0,  0, 0, 0, 64'h0,  0, 1);
    v1[10] = mk(1, 64'hA,  0, 0, 0, 64'h0,  0, 1);
    v1[11] = mk(1, 64'hB,  0, 0, 1, 64'hA,  1, 1);
    v1[12] = mk(1, 64'hC,  0, 0, 1, 64'hA,  2, 0);
    v1[13] = mk(1, 64'hC,  0, 0, 1, 64'hA,  2, 0);
    v1[14] = mk(1, 64'hC,  1, 0, 1, 64'hA,  2, 0);
    v1[15] = mk(1, 64'hC,  1, 0, 1, 64'hB,  1, 1);
    v1[16] = mk(0, 64'h0,  1, 0, 1, 64'hC,  1, 1);
    v1[17] = mk(0, 64'h0,  0, 0, 0, 64'h0,  0, 1);
    v1[18] = mk(1, 64'h10, 0, 0, 0, 64'h0,  0, 1);
    v1[19] = mk(1, 64'h11, 0, 0, 1, 64'h10, 1, 1);
    v1[20] = mk(1, 64'hD,  0, 1, 1, 64'h10, 2, 0);
    v1[21] = mk(0, 64'h0,  1, 0, 0, 64'h0,  0, 1);
    v1[22] = mk(1, 64'hE,  1, 1, 0, 64'h0,  0, 1);
    v1[23] = mk(0, 64'h0,  1, 0, 0, 64'h0,  0, 1);
    v1[24] = mk(1, 64'h20, 1, 0, 0, 64'h0,  0, 1);
    v1[25] = mk(0, 64'h0,  1, 1, 1, 64'h20, 1, 1);
    v1[26] = mk(0, 64'h0,  1, 0, 0, 64'h0,  0, 1);

    // SKID=0, bubble 0x13: same-cycle in_ready drop, in-place reload, drain, flush discard.
    v0[0] = mk(1, 64'h30, 0, 0, 0, 64'h13, 0, 1);
    v0[1] = mk(1, 64'h31, 0, 0, 1, 64'h30, 1, 0);
    v0[2] = mk(1, 64'h31, 1, 0, 1, 64'h30, 1, 1);
    v0[3] = mk(0, 64'h0,  1, 0, 1, 64'h31, 1, 1);
    v0[4] = mk(0, 64'h0,  0, 0, 0, 64'h13, 0, 1);
    v0[5] = mk(1, 64'h32, 1, 1, 0, 64'h13, 0, 1);
    v0[6] = mk(0, 64'h0,  0, 0, 0, 64'h13, 0, 1);

    do_reset();
    for (int i = 0; i < 27; i++) step(1'b1, v1[i], $sformatf("skid1[%0d]", i));
    for (int i = 0; i < 7; i++)  step(1'b0, v0[i], $sformatf("skid0[%0d]", i));

    // Reset together with flush while FULL, then a fresh beat 0x5.
    step(1'b1, mk(1, 64'hA1, 0, 0, 0, 64'h0,  0, 1), "rst_seq0");
    step(1'b1, mk(1, 64'hA2, 0, 0, 1, 64'hA1, 1, 1), "rst_seq1");
    @(negedge clk);
    in1.valid = 1'b1; in1.data = 64'hA3; out1.ready = 1'b0;
    rst = 1'b1; flush1 = 1'b1;
    #1;
    chk("rst_seq2.lvl", 64'(level1), 64'd2);
    @(posedge clk);
    #1;
    rst = 1'b0; flush1 = 1'b0;
    step(1'b1, mk(1, 64'h5, 1, 0, 0, 64'h0, 0, 1), "rst_seq3");
    step(1'b1, mk(0, 64'h0, 1, 0, 1, 64'h5, 1, 1), "rst_seq4");
    step(1'b1, mk(0, 64'h0, 1, 0, 0, 64'h0, 0, 1), "rst_seq5");

    // Random soak on both instances.
    do_reset();
    q[0].delete();
    q[1].delete();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      in1.valid  = ($urandom_range(0, 3) != 0);
      in1.data   = {$urandom, $urandom};
      out1.ready = ($urandom_range(0, 2) != 0);
      flush1     = ($urandom_range(0, 63) == 0);
      in0.valid  = ($urandom_range(0, 3) != 0);
      in0.data   = {$urandom, $urandom};
      out0.ready = ($urandom_range(0, 2) != 0);
      flush0     = ($urandom_range(0, 63) == 0);
      #1;
      soak_chk(1, in1.valid, in1.ready, in1.data, out1.valid, out1.ready, out1.data,
               flush1, level1);
      soak_chk(0, in0.valid, in0.ready, in0.data, out0.valid, out0.ready, out0.data,
               flush0, level0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
